// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_pkg
// Purpose  : Shared types and constants for the MIPS data-port bridge.
//            It holds the bridge FSM state type, the byte-enable and
//            word-alignment constants, and the default timeout value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    // Full-word access on every request; the CPU merges sub-words itself.
    localparam logic [3:0] BYTEEN_ALL = 4'b1111;

    // Byte-offset bits that are cleared to form a word-aligned address.
    localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/bridge_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bridge_timeout_counter
// Purpose  : Counts the wait cycles of one bus transaction. 'expired' is
//            high once TIMEOUT_CYCLES-1 wait edges have been counted, so a
//            further wait edge would be the TIMEOUT_CYCLES-th one.
// Ports    : clk     - clock, rising edge
//            reset   - synchronous, active-low
//            clear   - restart the count at zero (transaction launch)
//            enable  - count this cycle (a wait cycle)
//            expired - count has reached its final value
// Revision : 1.0 - initial release
// ============================================================================
module bridge_timeout_counter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            // Saturate at the final value; the owner aborts on that edge.
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/mips_data_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mips_data_bridge
// Purpose  : Adapts the CPU data port (combinational reads, single-cycle
//            writes) to a waitrequest-style memory bus. The CPU is frozen
//            through its clock-enable while a transaction is outstanding and
//            released for one enabled cycle with the read data held stable.
//            Provides a transaction timeout and a sticky bus-error flag.
// Ports    : clk, reset (sync, active-low)
//            ext_enable      - system clock-enable request
//            cpu_clk_enable  - CPU clock-enable (ext_enable & ~stall)
//            data_*          - CPU data port
//            mem_*           - memory bus (registered request outputs)
//            bus_error       - sticky error (timeout or read+write strobe)
// Revision : 1.0 - initial release
// ============================================================================
module mips_data_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_enable,
    output logic              cpu_clk_enable,
    input  logic [ADDR_W-1:0] data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [DATA_W-1:0] data_writedata,
    output logic [DATA_W-1:0] data_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              bus_error
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_OFFSET_MASK);

    bridge_state_t     state;
    bridge_state_t     next_state;
    logic              stall;
    logic              strobe;
    logic              launch;
    logic              complete;
    logic              abort;
    logic              tmo_expired;
    logic [DATA_W-1:0] rdata_q;

    assign strobe   = data_read | data_write;
    assign launch   = (state == IDLE) && strobe && ext_enable;
    // Completion wins over a timeout that lands on the same edge.
    assign complete = (state == BUSY) && !mem_waitrequest;
    assign abort    = (state == BUSY) && mem_waitrequest && tmo_expired;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                stall = strobe;
                if (launch) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                // ext_enable is deliberately ignored: a launched
                // transaction cannot be withdrawn.
                stall = 1'b1;
                if (complete || abort) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (ext_enable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            rdata_q       <= '0;
            bus_error     <= 1'b0;
        end else if (launch) begin
            mem_address   <= data_address & ALIGN_MASK;
            mem_writedata <= data_writedata;
            // Read and write together is resolved as a write plus error.
            mem_write     <= data_write;
            mem_read      <= data_read & ~data_write;
            if (data_read && data_write) begin
                bus_error <= 1'b1;
            end
        end else if (complete || abort) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (abort) begin
                rdata_q   <= '0;
                bus_error <= 1'b1;
            end else if (mem_read) begin
                rdata_q <= mem_readdata;
            end
        end
    end

    bridge_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (launch),
        .enable  ((state == BUSY) && mem_waitrequest),
        .expired (tmo_expired)
    );

    assign cpu_clk_enable = ext_enable & ~stall;
    assign data_readdata  = rdata_q;
    assign mem_byteenable = BYTEEN_ALL;

endmodule
`default_nettype wire

// File: tb/tb_mips_data_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_data_bridge
// Purpose  : Self-checking bench for mips_data_bridge. A CPU driver issues
//            directed and random accesses and pushes the predicted outcome
//            into queues; a memory device model and a CPU-side monitor pop
//            and compare independently.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_data_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ext_enable = 1'b0;
    logic        cpu_clk_enable;
    logic [31:0] data_address = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = '0;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b1;
    logic [31:0] mem_readdata = '0;
    logic        bus_error;

    always #5 clk = ~clk;

    mips_data_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ext_enable      (ext_enable),
        .cpu_clk_enable  (cpu_clk_enable),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .bus_error       (bus_error)
    );

    typedef struct {
        logic [31:0] addr;
        bit          is_write;
        logic [31:0] wdata;
        int          waits;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state (what the CPU should observe)
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_last = '0;
    bit          ref_err  = 1'b0;

    // Memory device storage
    logic [31:0] dev_mem [logic [31:0]];

    bit force_en  = 1'b1;
    bit abort_run = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ext_enable: held high in directed phases, random otherwise
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ext_enable = force_en ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // Memory device model
    bit          mm_in_prog = 1'b0;
    int          mm_left    = 0;
    req_t        mm_cur;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (!mm_in_prog) begin
                    mm_in_prog = 1'b1;
                    if (req_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request: actual addr=0x%08h required=no request", mem_address);
                        mm_cur.addr     = mem_address;
                        mm_cur.is_write = mem_write;
                        mm_cur.wdata    = mem_writedata;
                        mm_cur.waits    = 0;
                    end else begin
                        mm_cur = req_q.pop_front();
                        check("req_addr", mem_address, mm_cur.addr);
                        check("req_kind", {30'b0, mem_write, mem_read}, mm_cur.is_write ? 32'd2 : 32'd1);
                        if (mm_cur.is_write) begin
                            check("req_wdata", mem_writedata, mm_cur.wdata);
                        end
                        check("req_byteen", 32'(mem_byteenable), 32'hF);
                    end
                    mm_left = mm_cur.waits;
                end else begin
                    check("req_hold_addr", mem_address, mm_cur.addr);
                    mm_left--;
                end
                mem_waitrequest = (mm_left > 0);
                if (mm_left == 0) begin
                    if (mem_write) begin
                        dev_mem[mem_address] = mem_writedata;
                    end else begin
                        mem_readdata = dev_mem.exists(mem_address) ? dev_mem[mem_address]
                                                                    : init_word(mem_address);
                    end
                end else begin
                    mem_readdata = $urandom;
                end
            end else begin
                mm_in_prog      = 1'b0;
                mem_waitrequest = ($urandom_range(0, 1) != 0);
                mem_readdata    = $urandom;
            end
        end
    end

    // CPU-side monitor: compares at every retiring (enabled, strobed) cycle
    rsp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset && cpu_clk_enable && (data_read || data_write)) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: actual rdata=0x%08h required=no retire", data_readdata);
                end else begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_rdata", data_readdata, mon_e.rdata);
                    check("rsp_bus_error", 32'(bus_error), 32'(mon_e.err));
                end
            end
        end
    end

    // Issue one CPU access; returns after the retiring edge.
    task automatic do_txn(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wdata, input int waits, input bit chk_lat);
        req_t        r;
        rsp_t        e;
        int          cyc;
        bit          done_ok;
        logic [31:0] a;
        bit          tmo;
        a   = addr & 32'hFFFF_FFFC;
        tmo = (waits >= TMO);
        if (rd && wr) ref_err = 1'b1;
        if (tmo) begin
            ref_err  = 1'b1;
            ref_last = '0;
        end else if (wr) begin
            ref_mem[a] = wdata;
        end else begin
            ref_last = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        end
        r.addr = a; r.is_write = wr; r.wdata = wdata; r.waits = waits;
        req_q.push_back(r);
        e.rdata = ref_last; e.err = ref_err;
        rsp_q.push_back(e);

        data_address   = addr;
        data_read      = rd;
        data_write     = wr;
        data_writedata = wdata;
        cyc     = 0;
        done_ok = 1'b0;
        while (!done_ok && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cpu_clk_enable) done_ok = 1'b1;
        end
        if (!done_ok) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: actual=no retire after %0d cycles required=retire", cyc);
            abort_run = 1'b1;
        end else if (chk_lat) begin
            check("latency", 32'(cyc), tmo ? 32'(TMO + 2) : 32'(waits + 3));
        end
        @(posedge clk);
        #1;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic random_txns(input int n);
        int k;
        int w;
        for (int i = 0; i < n && !abort_run; i++) begin
            k = $urandom_range(0, 19);
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
            do_txn(32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3),
                   (k < 10) || (k == 19), (k >= 10), $urandom, w, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int guard;
        dev_mem[32'h1004] = 32'hDEADBEEF;
        ref_mem[32'h1004] = 32'hDEADBEEF;
        dev_mem[32'h4000] = 32'hCAFEF00D;
        ref_mem[32'h4000] = 32'hCAFEF00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_mem_address", mem_address, 32'd0);
        check("reset_mem_writedata", mem_writedata, 32'd0);
        check("reset_readdata", data_readdata, 32'd0);
        check("reset_bus_error", 32'(bus_error), 32'd0);
        check("reset_clk_enable", 32'(cpu_clk_enable), 32'(ext_enable));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed, ext_enable held high so latency is exact
        do_txn(32'h1004, 1'b1, 1'b0, 32'h0, 0, 1'b1);
        do_txn(32'h2002, 1'b0, 1'b1, 32'h12345678, 3, 1'b1);
        do_txn(32'h2000, 1'b1, 1'b0, 32'h0, 1, 1'b1);
        do_txn(32'h4000, 1'b1, 1'b0, 32'h0, 2, 1'b1);
        do_txn(32'h1004, 1'b1, 1'b0, 32'h0, TMO, 1'b1);
        do_txn(32'h3000, 1'b1, 1'b1, 32'hA1B2C3D4, 0, 1'b1);
        do_txn(32'h3000, 1'b1, 1'b0, 32'h0, 0, 1'b1);

        // Random accesses with random ext_enable
        force_en = 1'b0;
        random_txns(150);

        // Reset while BUSY
        force_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        if (!abort_run) begin
            req_t r;
            r.addr = 32'h104; r.is_write = 1'b0; r.wdata = '0; r.waits = 50;
            req_q.push_back(r);
            data_address = 32'h104;
            data_read    = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!mem_read && guard < 20);
            check("midbusy_launch", 32'(mem_read), 32'd1);
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk);
            #1;
            reset     = 1'b1;
            data_read = 1'b0;
            @(negedge clk);
            check("midbusy_mem_read", 32'(mem_read), 32'd0);
            check("midbusy_readdata", data_readdata, 32'd0);
            check("midbusy_bus_error", 32'(bus_error), 32'd0);
            check("midbusy_clk_enable", 32'(cpu_clk_enable), 32'd1);
            ref_last = '0;
            ref_err  = 1'b0;
            @(posedge clk);
            #1;
            do_txn(32'h1004, 1'b1, 1'b0, 32'h0, 0, 1'b1);
            force_en = 1'b0;
            random_txns(20);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_data_bridge.md
Name: mips_data_bridge

Overview:
Sits between the CPU data port (data_address/data_read/data_write/data_writedata/data_readdata) and a wait-state data memory on a waitrequest-style bus.
- The CPU expects combinational reads and single-cycle writes. The bridge stalls the CPU through its clock-enable until the memory transaction completes, then releases it for exactly one enabled cycle with the read data held stable.
- Also provides a transaction timeout and a sticky bus-error flag.

Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width on both sides
- TIMEOUT_CYCLES, 255, maximum cycles BUSY may wait on mem_waitrequest before aborting
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge of clk resets the block
- ext_enable  in  1  testbench/system clock-enable request
- cpu_clk_enable  out  1  drives CPU clk_enable; = ext_enable & ~stall
- data_address  in  ADDR_W  CPU data address
- data_read  in  1  CPU read strobe
- data_write  in  1  CPU write strobe
- data_writedata  in  DATA_W  CPU write data
- data_readdata  out  DATA_W  read data to CPU
- mem_address  out  ADDR_W  registered, word-aligned {addr[31:2],2'b00}
- mem_read  out  1  registered read request
- mem_write  out  1  registered write request
- mem_writedata  out  DATA_W  registered write data
- mem_byteenable  out  4  always 4'b1111; CPU merges sub-words
- mem_waitrequest  in  1  memory not ready; request held while 1
- mem_readdata  in  DATA_W  valid in the cycle waitrequest==0 with mem_read==1
- bus_error  out  1  sticky error flag

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (reset==0 at edge): state=IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, rdata_q=0, timeout counter=0, bus_error=0.
  - A reset mid-transaction aborts it; the memory sees the request drop on the next cycle.
  - cpu_clk_enable=ext_enable while IDLE.
- IDLE:
  - stall = data_read|data_write (combinational).
  - If a strobe is set and ext_enable==1: at the edge, latch the aligned address and write data, assert mem_read or mem_write, clear the counter, go to BUSY.
  - If ext_enable==0, stay IDLE (the CPU is frozen anyway).
- BUSY:
  - stall=1; request outputs held constant.
  - Edge with mem_waitrequest==0: if reading, rdata_q<=mem_readdata; drop mem_read/mem_write; go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: abort, rdata_q<=0, bus_error<=1, go to DONE.
  - ext_enable is ignored in BUSY; a transaction cannot be withdrawn.
- DONE:
  - stall=0, so cpu_clk_enable=ext_enable.
  - data_readdata=rdata_q.
  - If ext_enable==1: go to IDLE at the edge (the CPU retires the instruction at that same edge). Otherwise hold DONE with rdata_q stable.
- data_readdata = rdata_q in every state. The CPU only samples it when enabled, which is DONE.
- Latency, zero-wait memory: 3 cycles per access (IDLE detect, BUSY, DONE). N wait cycles add N.
  - Back-to-back accesses: a new strobe seen in the IDLE cycle after DONE starts a new transaction, with no idle bubble beyond that cycle.
- Read and write both asserted: treated as a write, read ignored, bus_error<=1 at the launch edge.
- bus_error clears only on reset.
- Write completion: write data is committed by the memory at the edge where waitrequest==0. The CPU sees the write complete in DONE.

Decomposition:
- Shared package mips_bus_pkg:
  - state enum {IDLE, BUSY, DONE}
  - BYTEEN_ALL=4'b1111
  - word-align mask constant
  - the default TIMEOUT_CYCLES value
- One natural sub-module, bridge_timeout_counter: clear, enable and expired output, parameterised by TIMEOUT_CYCLES/CNT_W.

Test Plan:
- Zero-wait read: addr 0x1004, memory returns 0xDEADBEEF with waitrequest=0 → mem_read high 1 cycle at 0x1004; cpu_clk_enable low 2 cycles, high in DONE with data_readdata=0xDEADBEEF.
- Write with 3 wait cycles: addr 0x2002, data 0x12345678 → mem_address=0x2000, mem_write high 4 cycles, byteenable=4'hF; stall lasts 5 cycles; bus_error=0.
- Timeout: TIMEOUT_CYCLES=4, waitrequest stuck 1 → abort after 4 BUSY cycles; data_readdata=0, bus_error=1 and sticky through later good accesses.
- ext_enable low during BUSY and DONE: waitrequest drops while ext_enable=0 → the transaction completes and DONE holds 0xCAFEF00D until ext_enable=1; then one enabled cycle, then IDLE.
- Reset mid-BUSY: reset=0 for 1 edge with mem_read=1 → next cycle IDLE, mem_read=0, data_readdata=0, bus_error=0.
- Simultaneous read and write to 0x3000 → write issued only, mem_read=0, bus_error=1.
